sn_frame_reader: RTL and testbench
==================================

// Module: sn_frame_reader
// PURPOSE
//  Reader end of the c2_sn analysis buffer (320 x 32-bit, Q16.16). On start, it reads LEN
//  samples from the buffer RAM port, beginning at BASE and wrapping modulo DEPTH.
//  It presents them one at a time on a valid/ready stream to the downstream analysis
//  stage (nlp / window).
//  It complements the frame loader that writes 80 new samples at addresses 240..319.
// PARAMETERS
//  N       32    sample width (Q16.16 fixed point)
//  Q       16    fractional bits; carried through only, no arithmetic on data
//  DEPTH   320   buffer depth (M_PITCH); address wrap point
//  RD_LAT  3     cycles from ram_addr/ram_re stable to ram_rdata valid (1..7)
// PORTS
//  clk           in   1    clock, rising edge
//  rst           in   1    asynchronous, active-low reset
//  start_read    in   1    level; sampled in IDLE/DONE, launches a read pass
//  base_addr     in   10   first buffer address; latched at start
//  len           in   10   number of samples to read; latched at start
//  ram_addr      out  10   buffer RAM address
//  ram_re        out  1    buffer RAM read enable
//  ram_we        out  1    buffer RAM write enable; always 0
//  ram_wdata     out  N    buffer RAM write data; always 0
//  ram_rdata     in   N    buffer RAM read data
//  sample_out    out  N    stream data
//  sample_valid  out  1    stream valid
//  sample_ready  in   1    stream ready from consumer
//  sample_last   out  1    high with the final sample of the pass
//  busy          out  1    high from launch until DONE is entered
//  done_read     out  1    sticky completion flag
//  err_base      out  1    one-cycle pulse when a start is rejected
// BEHAVIOUR
//  Reset (async, rst=0): all outputs are 0, FSM goes to IDLE, index cnt=0.
//  States and transitions:
//   IDLE -> SET_ADDR when start_read=1; len and base are latched.
//   SET_ADDR -> WAIT: ram_addr and ram_re=1 are driven; wait counter is cleared.
//   WAIT -> CAPTURE after RD_LAT-1 wait cycles; ram_addr and ram_re are held stable throughout.
//   CAPTURE -> PRESENT: sample_out is registered from ram_rdata.
//   PRESENT -> INCR when sample_ready=1. Stays in PRESENT while sample_ready=0.
//   INCR -> SET_ADDR if cnt+1 < len, else -> DONE. cnt is incremented here.
//   DONE: done_read=1 and busy=0. If start_read=1, go to SET_ADDR with new latches and done_read cleared.
//  Stream rules:
//   - sample_valid=1 only in PRESENT.
//   - sample_out and sample_last stay stable while valid=1 and ready=0.
//   - A transfer occurs on the edge where valid and ready are both 1.
//   - sample_last = valid & (cnt == len-1).
//  Per-sample latency: RD_LAT+3 cycles when ready is held high.
//  Address: sum = base + cnt, 11 bits wide. ram_addr = (sum >= DEPTH) ? sum-DEPTH : sum.
//  Boundary cases:
//   - len=0: go directly to DONE; no RAM read and no valid.
//   - len > DEPTH: len is clamped to DEPTH.
//   - base_addr >= DEPTH: the start is rejected; err_base pulses 1 cycle; state is unchanged.
//   - start_read while busy: ignored; the latched base/len stay unchanged.
//   - Reset mid-pass: abort immediately; outputs clear and no partial done_read is raised.
//   - ready asserted early, before valid: has no effect.
//  ram_we and ram_wdata are constant 0; the block never writes the buffer.
// STRUCTURE
//  Shared package c2_buf_pkg holds:
//   - N, Q, DEPTH=320, N_SAMP=80, and the FSM state encoding.
//   - The addr_wrap function (base+offset mod DEPTH), which the frame loader reuses.
//  The FSM uses two processes: a registered state, and combinational next state and RAM drive.
//  Outputs are registered.
//  No sub-module is needed; the RD_LAT wait counter stays inline, 3 bits wide.
// TESTING
//  Use the RAM model with RD_LAT=3 and mem[a] = a<<16.
//  1. base=240, len=80, ready=1 -> 80 beats of data 240..319 (Q16) in order; last on beat 80;
//     done_read=1 next cycle.
//  2. base=300, len=40 -> addrs 300..319 then 0..19; beat 21 data = 0x0000_0000.
//  3. ready low for 5 cycles on beat 3 -> sample_out stays 242<<16; no RAM re-read;
//     no beat lost or duplicated.
//  4. len=0 -> DONE within 2 cycles; sample_valid never 1.
//     base=320 -> err_base pulses 1 cycle; stays IDLE.
//  5. rst=0 during beat 10 of a 320-sample pass -> all outputs 0 asynchronously;
//     a fresh start yields beat 1 = base.
//  6. start_read toggled mid-pass with base=0 -> ignored.
//     Restart from DONE with len=1 -> one beat, valid and last together.

Source files
------------

// File: rtl/c2_buf_pkg.sv
// ============================================================================
//  c2_buf_pkg : shared definitions for the c2_sn analysis buffer
//  Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package c2_buf_pkg;

  localparam int N      = 32;   // sample width, Q16.16
  localparam int Q      = 16;   // fractional bits
  localparam int DEPTH  = 320;  // buffer depth (M_PITCH)
  localparam int N_SAMP = 80;   // samples written per frame by the loader
  localparam int AW     = 10;   // buffer address width

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_ADDR = 3'd1,
    ST_WAIT     = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_PRESENT  = 3'd4,
    ST_INCR     = 3'd5,
    ST_DONE     = 3'd6
  } rd_state_e;

  // Both operands are below depth, so one conditional subtract wraps the sum.
  function automatic logic [AW-1:0] addr_wrap(input logic [AW-1:0] base,
                                              input logic [AW-1:0] offset,
                                              input logic [AW:0]   depth);
    logic [AW:0] sum;
    sum = {1'b0, base} + {1'b0, offset};
    return (sum >= depth) ? AW'(sum - depth) : sum[AW-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sn_frame_reader.sv
// ============================================================================
//  sn_frame_reader : reads LEN samples from the analysis buffer (wrapping at
//                    DEPTH) and streams them out on a valid/ready interface
//  Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module sn_frame_reader #(
  parameter int N      = c2_buf_pkg::N,
  parameter int DEPTH  = c2_buf_pkg::DEPTH,
  parameter int RD_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_read,
  input  logic [9:0]   base_addr,
  input  logic [9:0]   len,
  output logic [9:0]   ram_addr,
  output logic         ram_re,
  output logic         ram_we,
  output logic [N-1:0] ram_wdata,
  input  logic [N-1:0] ram_rdata,
  output logic [N-1:0] sample_out,
  output logic         sample_valid,
  input  logic         sample_ready,
  output logic         sample_last,
  output logic         busy,
  output logic         done_read,
  output logic         err_base
);
  import c2_buf_pkg::*;

  localparam logic [10:0] DEPTH_W   = 11'(DEPTH);
  localparam logic [2:0]  WAIT_LAST = 3'((RD_LAT >= 2) ? RD_LAT - 2 : 0);

  rd_state_e      state_q, state_d;
  logic [9:0]     base_q, base_d;
  logic [9:0]     len_q, len_d;
  logic [9:0]     cnt_q, cnt_d;
  logic [2:0]     wait_q, wait_d;
  logic [9:0]     ram_addr_q, ram_addr_d;
  logic           ram_re_q;
  logic [N-1:0]   sample_q, sample_d;
  logic           valid_q, last_q, busy_q, done_q;
  logic           err_q, err_d;
  logic [9:0]     len_clamped;

  assign len_clamped = ({1'b0, len} > DEPTH_W) ? DEPTH_W[9:0] : len;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_read) begin
          if ({1'b0, base_addr} >= DEPTH_W) begin
            err_d = 1'b1;
          end else begin
            base_d  = base_addr;
            len_d   = len_clamped;
            cnt_d   = '0;
            state_d = (len_clamped == '0) ? ST_DONE : ST_SET_ADDR;
          end
        end
      end
      ST_SET_ADDR: begin
        wait_d  = '0;
        state_d = (RD_LAT > 1) ? ST_WAIT : ST_CAPTURE;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_CAPTURE;
        else                     wait_d  = wait_q + 3'd1;
      end
      ST_CAPTURE: state_d = ST_PRESENT;
      ST_PRESENT: if (sample_ready) state_d = ST_INCR;
      ST_INCR: begin
        cnt_d   = cnt_q + 10'd1;
        state_d = ({1'b0, cnt_q} + 11'd1 < {1'b0, len_q}) ? ST_SET_ADDR : ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address is loaded on entry to SET_ADDR and held until the next sample.
  always_comb begin
    ram_addr_d = ram_addr_q;
    if (state_d == ST_SET_ADDR) ram_addr_d = addr_wrap(base_d, cnt_d, DEPTH_W);
    sample_d = (state_q == ST_CAPTURE) ? ram_rdata : sample_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      ram_addr_q <= '0;
      ram_re_q   <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      ram_addr_q <= ram_addr_d;
      ram_re_q   <= (state_d == ST_SET_ADDR) || (state_d == ST_WAIT) ||
                    (state_d == ST_CAPTURE);
      sample_q   <= sample_d;
      valid_q    <= (state_d == ST_PRESENT);
      last_q     <= (state_d == ST_PRESENT) && (cnt_d == len_d - 10'd1);
      busy_q     <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q     <= (state_d == ST_DONE);
      err_q      <= err_d;
    end
  end

  assign ram_addr     = ram_addr_q;
  assign ram_re       = ram_re_q;
  assign ram_we       = 1'b0;
  assign ram_wdata    = '0;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign sample_last  = last_q;
  assign busy         = busy_q;
  assign done_read    = done_q;
  assign err_base     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sn_frame_reader.sv
// ============================================================================
//  tb_sn_frame_reader : randomized scoreboard bench for sn_frame_reader
//  Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module tb_sn_frame_reader;

  localparam int RD_LAT = 3;

  logic        clk, rst, start_read, sample_ready;
  logic [9:0]  base_addr, len, ram_addr;
  logic        ram_re, ram_we, sample_valid, sample_last, busy, done_read, err_base;
  logic [31:0] ram_wdata, ram_rdata, sample_out;

  sn_frame_reader #(.N(32), .DEPTH(320), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start_read(start_read), .base_addr(base_addr), .len(len),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .sample_out(sample_out), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_last(sample_last), .busy(busy),
    .done_read(done_read), .err_base(err_base)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer RAM model: mem[a] = a<<16, RD_LAT-stage read pipeline
  logic [31:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= ram_re ? (32'(ram_addr) << 16) : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[RD_LAT-1];

  typedef struct { logic [31:0] d; logic l; } exp_t;
  exp_t q[$];

  int errors = 0, checks = 0;
  int beats = 0, reads = 0, valid_seen = 0, err_seen = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by main sequence

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the pass yields samples (base+i) mod 320 for i < min(len,320)
  task automatic model_push(input int b, input int l);
    int n;
    exp_t e;
    if (b >= 320) return;
    n = (l > 320) ? 320 : l;
    for (int i = 0; i < n; i++) begin
      e.d = 32'((b + i) % 320) << 16;
      e.l = (i == n - 1);
      q.push_back(e);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0)      sample_ready = 1'b1;
      else if (rdy_mode == 1) sample_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks stall stability
  initial begin
    logic        hold_pend, hold_l, re_prev;
    logic [31:0] hold_d;
    exp_t        e;
    hold_pend = 1'b0; re_prev = 1'b0; hold_d = '0; hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin hold_pend = 1'b0; re_prev = 1'b0; continue; end
      if (sample_valid) valid_seen++;
      if (hold_pend) begin
        chk("stall_valid", sample_valid, 1);
        chk("stall_data", sample_out, hold_d);
        chk("stall_last", sample_last, hold_l);
      end
      hold_pend = 1'b0;
      if (sample_valid && sample_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got data %0h with empty scoreboard", sample_out);
        end else begin
          e = q.pop_front();
          chk("beat_data", sample_out, e.d);
          chk("beat_last", sample_last, e.l);
        end
        beats++;
      end else if (sample_valid) begin
        hold_pend = 1'b1; hold_d = sample_out; hold_l = sample_last;
      end
      if (ram_re && !re_prev) reads++;
      re_prev = ram_re;
      if (err_base) err_seen++;
    end
  end

  function automatic logic any_out();
    return |{ram_addr, ram_re, ram_we, ram_wdata, sample_out, sample_valid,
             sample_last, busy, done_read, err_base};
  endfunction

  task automatic launch(input int b, input int l);
    @(posedge clk); #1;
    base_addr = 10'(b); len = 10'(l); start_read = 1'b1;
    @(posedge clk); #1;
    start_read = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_read !== 1'b1 && n < budget) begin @(posedge clk); #1; n++; end
    chk("done_timeout", done_read, 1);
  endtask

  task automatic run_pass(input int b, input int l, input int mode);
    int n;
    n = (l > 320) ? 320 : l;
    rdy_mode = mode;
    model_push(b, l);
    reads = 0;
    launch(b, l);
    if (n > 0) chk("busy_after_launch", busy, 1);
    wait_done(n * 30 + 100);
    repeat (2) @(posedge clk); #1;
    chk("beats_missing", q.size(), 0);
    chk("ram_reads", reads, n);
    chk("busy_at_done", busy, 0);
    chk("never_writes", {ram_we, |ram_wdata}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    #1 chk("async_reset_outputs", any_out(), 0);
    q.delete();
    @(negedge clk); #2;
    rst = 1'b1;
  endtask

  initial begin
    int n, b;
    rst = 1'b0; start_read = 1'b0; base_addr = '0; len = '0; sample_ready = 1'b0;
    #1 chk("reset_outputs", any_out(), 0);
    #21 rst = 1'b1;

    run_pass(240, 80, 0);   // loader region, ready held high
    run_pass(300, 40, 1);   // wraps past 319 to 0, random ready

    // Five-cycle stall on beat 3
    rdy_mode = 2; sample_ready = 1'b0;
    model_push(240, 6); reads = 0;
    launch(240, 6);
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (sample_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      chk("beat_wait", sample_valid, 1);
      if (k == 2) begin
        chk("beat3_data", sample_out, 32'd242 << 16);
        repeat (5) begin @(posedge clk); #1; end
      end
      sample_ready = 1'b1;
      @(posedge clk); #1;
      sample_ready = 1'b0;
    end
    wait_done(100);
    chk("stall_reads", reads, 6);
    chk("stall_beats_missing", q.size(), 0);

    // len = 0 from IDLE
    do_reset();
    valid_seen = 0; reads = 0; rdy_mode = 0;
    launch(50, 0);
    chk("len0_done", done_read, 1);
    chk("len0_busy", busy, 0);
    repeat (3) @(posedge clk); #1;
    chk("len0_no_valid", valid_seen, 0);
    chk("len0_no_read", reads, 0);

    // base out of range from IDLE
    do_reset();
    err_seen = 0;
    launch(320, 10);
    chk("err_pulse", err_base, 1);
    chk("err_busy", busy, 0);
    chk("err_done", done_read, 0);
    @(posedge clk); #1;
    chk("err_one_cycle", err_base, 0);
    repeat (3) @(posedge clk); #1;
    chk("err_count", err_seen, 1);
    chk("err_stays_idle", busy, 0);

    run_pass(17, 500, 1);   // clamped to 320 samples

    // Reset during beat 10 of a full pass
    b = int'($urandom_range(0, 319));
    rdy_mode = 1; model_push(b, 320); beats = 0;
    launch(b, 320);
    n = 0;
    while (!(beats >= 9 && sample_valid === 1'b1) && n < 5000) begin @(posedge clk); #1; n++; end
    chk("beat10_reached", sample_valid, 1);
    #2 rst = 1'b0;
    #1 chk("midpass_reset_outputs", any_out(), 0);
    q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    chk("no_partial_done", done_read, 0);
    run_pass(int'($urandom_range(0, 319)), 12, 0);

    // start_read pulsed mid-pass is ignored
    rdy_mode = 0; model_push(100, 30); reads = 0; err_seen = 0;
    launch(100, 30);
    repeat (20) @(posedge clk); #1;
    base_addr = 10'd0; len = 10'd5; start_read = 1'b1;
    @(posedge clk); #1;
    start_read = 1'b0;
    wait_done(1000);
    repeat (2) @(posedge clk); #1;
    chk("toggle_beats_missing", q.size(), 0);
    chk("toggle_reads", reads, 30);

    run_pass(77, 1, 0);     // restart from DONE, single beat with last

    for (int r = 0; r < 8; r++)
      run_pass(int'($urandom_range(0, 319)), int'($urandom_range(0, 50)), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
